// File: rtl/clos_cm_pkg.sv
// Shared types and helpers for the synchronous Clos central module.
//   clog2          : ceiling log2 for sizing pointers and indices
//   onehot_lowest  : index of the lowest set bit (32 when the vector is zero)
//   in_st_t        : per-input packet state (IDLE = head flit expected)
//   PW             : FIFO pointer width for the default depth
package clos_cm_pkg;
  localparam int KN_DEF = 5;
  localparam int DW_DEF = 8;
  localparam int BD_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int PW = clog2(BD_DEF) + 1;

  function automatic int onehot_lowest(input logic [31:0] v);
    int r;
    r = 32;
    for (int k = 31; k >= 0; k--) if (v[k]) r = k;
    return r;
  endfunction

  typedef enum logic {IDLE = 1'b0, BOUND = 1'b1} in_st_t;
endpackage

// File: rtl/clos_rr_arb.sv
// Round-robin arbiter over N requesters, one instance per CM output.
//   req     : request vector
//   ptr     : index of the highest-priority requester this cycle
//   gnt     : one-hot grant (zero when nobody requests)
//   gnt_vld : any grant issued
module clos_rr_arb
  import clos_cm_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld
);
  logic [N-1:0] rot;
  int           w;

  // Rotate requests so the pointer position lands on bit 0; the lowest set
  // bit of the rotated vector is the winner, offset back by ptr.
  always_comb begin
    rot     = N'({req, req} >> ptr);
    w       = onehot_lowest(32'(rot));
    gnt_vld = |req;
    gnt     = '0;
    for (int k = 0; k < N; k++)
      gnt[k] = gnt_vld && (((w + int'(ptr)) % N) == k);
  end
endmodule

// File: rtl/clos_cm_sync.sv
// Synchronous buffered central module of the SDM-Clos router.
// KN inputs with BD-deep flit FIFOs are switched wormhole style onto KN
// outputs; each output has a round-robin arbiter with packet locking.
//   clk, rst          : clock, synchronous active-high reset
//   in_data/eof/dec   : input flit, tail flag, one-hot output request
//   in_vld / in_rdy   : input handshake (in_rdy is registered !full)
//   out_data/eof      : output flit and tail flag
//   out_vld / out_rdy : output handshake toward the OM stage
// Optional: define CLOS_CM_BYPASS_EN to let a flit arriving at an empty
// FIFO reach the crossbar in the same cycle; it is stored only if it does
// not leave immediately.
module clos_cm_sync
  import clos_cm_pkg::*;
#(
  parameter int KN = KN_DEF,
  parameter int DW = DW_DEF,
  parameter int BD = BD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KN*DW-1:0]  in_data,
  input  logic [KN-1:0]     in_eof,
  input  logic [KN*KN-1:0]  in_dec,
  input  logic [KN-1:0]     in_vld,
  output logic [KN-1:0]     in_rdy,
  output logic [KN*DW-1:0]  out_data,
  output logic [KN-1:0]     out_eof,
  output logic [KN-1:0]     out_vld,
  input  logic [KN-1:0]     out_rdy
);
  localparam int AW   = clog2(BD);
  localparam int PTRW = AW + 1;
  localparam int IW   = (KN > 1) ? clog2(KN) : 1;
  localparam int EW   = 1 + KN + DW;   // {eof, dec, data}

  logic [EW-1:0]   mem_q [KN][BD];
  logic [EW-1:0]   mem_d [KN][BD];
  logic [PTRW-1:0] wptr_q [KN], wptr_d [KN];
  logic [PTRW-1:0] rptr_q [KN], rptr_d [KN];
  logic [PTRW-1:0] cnt_q  [KN], cnt_d  [KN];
  logic [KN-1:0]   rdy_q, rdy_d, drain_q, drain_d, lock_q, lock_d;
  in_st_t          st_q [KN], st_d [KN];
  logic [KN-1:0]   own_q [KN], own_d [KN];   // one-hot owner per output
  logic [IW-1:0]   rr_q  [KN], rr_d  [KN];

  logic [KN-1:0]   push, bp, avail, drop, pop, push_w, pop_f, xfer, gvld;
  logic [EW-1:0]   head [KN], in_ent [KN];
  logic [KN-1:0]   req [KN], gnt [KN], sel [KN];   // [output][input]

  assign in_rdy = rdy_q & ~{KN{rst}};

  // Input side: effective head flit, availability and drop decision.
  // drain_q keeps discarding the body of a packet whose head had dec=0.
  always_comb begin
    for (int i = 0; i < KN; i++) begin
      push[i]   = in_vld[i] & in_rdy[i];
      in_ent[i] = {in_eof[i], in_dec[i*KN +: KN], in_data[i*DW +: DW]};
`ifdef CLOS_CM_BYPASS_EN
      bp[i]     = push[i] && (cnt_q[i] == '0);
`else
      bp[i]     = 1'b0;
`endif
      head[i]   = bp[i] ? in_ent[i] : mem_q[i][rptr_q[i][AW-1:0]];
      avail[i]  = bp[i] || (cnt_q[i] != '0);
      drop[i]   = avail[i] && (drain_q[i] ||
                  (st_q[i] == IDLE && head[i][DW +: KN] == '0));
      for (int o = 0; o < KN; o++)
        req[o][i] = avail[i] && !drain_q[i] && (st_q[i] == IDLE) &&
                    (onehot_lowest(32'(head[i][DW +: KN])) == o);
    end
  end

  for (genvar o = 0; o < KN; o++) begin : g_arb
    clos_rr_arb #(.N(KN), .IW(IW)) u_arb (
      .req     (req[o]),
      .ptr     (rr_q[o]),
      .gnt     (gnt[o]),
      .gnt_vld (gvld[o])
    );
  end

  // Crossbar: a locked output follows its owner, a free one its grant.
  always_comb begin
    pop      = drop;
    out_vld  = '0;
    out_data = '0;
    out_eof  = '0;
    xfer     = '0;
    for (int o = 0; o < KN; o++) begin
      sel[o] = lock_q[o] ? own_q[o] : (gvld[o] ? gnt[o] : '0);
      for (int i = 0; i < KN; i++)
        if (sel[o][i] && avail[i] && !rst) begin
          out_vld[o]            = 1'b1;
          out_data[o*DW +: DW]  = head[i][DW-1:0];
          out_eof[o]            = head[i][EW-1];
        end
      xfer[o] = out_vld[o] & out_rdy[o];
      for (int i = 0; i < KN; i++)
        if (sel[o][i] && xfer[o]) pop[i] = 1'b1;
    end
  end

  // Lock / pointer updates; only an actual transfer changes ownership.
  always_comb begin
    st_d    = st_q;
    own_d   = own_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    drain_d = drain_q;
    for (int o = 0; o < KN; o++) begin
      if (xfer[o]) begin
        if (lock_q[o]) begin
          if (out_eof[o]) begin
            lock_d[o] = 1'b0;
            own_d[o]  = '0;
            for (int i = 0; i < KN; i++) if (own_q[o][i]) st_d[i] = IDLE;
          end
        end else begin
          rr_d[o] = IW'((onehot_lowest(32'(sel[o])) + 1) % KN);
          if (!out_eof[o]) begin
            lock_d[o] = 1'b1;
            own_d[o]  = sel[o];
            for (int i = 0; i < KN; i++) if (sel[o][i]) st_d[i] = BOUND;
          end
        end
      end
    end
    for (int i = 0; i < KN; i++)
      if (drop[i]) drain_d[i] = !head[i][EW-1];
  end

  // FIFO bookkeeping. A bypassed flit that leaves immediately is never stored.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < KN; i++) begin
      push_w[i] = push[i] && !(bp[i] && pop[i]);
      pop_f[i]  = pop[i] && !bp[i];
      wptr_d[i] = wptr_q[i] + PTRW'(push_w[i]);
      rptr_d[i] = rptr_q[i] + PTRW'(pop_f[i]);
      cnt_d[i]  = cnt_q[i] + PTRW'(push_w[i]) - PTRW'(pop_f[i]);
      rdy_d[i]  = (cnt_d[i] != PTRW'(BD));
      if (push_w[i]) mem_d[i][wptr_q[i][AW-1:0]] = in_ent[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KN; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
        st_q[i]   <= IDLE;
        own_q[i]  <= '0;
        rr_q[i]   <= '0;
      end
      rdy_q   <= '1;   // masked by rst at the port, open on the first free cycle
      drain_q <= '0;
      lock_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      rdy_q   <= rdy_d;
      drain_q <= drain_d;
      lock_q  <= lock_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_clos_cm_sync.sv
module tb_clos_cm_sync;
  localparam int KN = 5;
  localparam int DW = 8;
  localparam int BD = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          eof;
    logic [KN-1:0] dec;
    int            dst;
  } flit_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [KN*DW-1:0] in_data;
  logic [KN-1:0]    in_eof, in_vld, in_rdy;
  logic [KN*KN-1:0] in_dec;
  logic [KN*DW-1:0] out_data;
  logic [KN-1:0]    out_eof, out_vld, out_rdy;

  int    checks = 0;
  int    failures = 0;
  flit_t send_q [KN][$];
  flit_t exp_q  [KN][$];
  int    gnt_log [KN][$];
  int    cur_in [KN];
  int    seq [KN];
  int    n_xfer = 0;
  bit    mon_en = 1'b0;
  int    vld_pct = 100;
  int    rdy_pct = 100;
  logic [KN-1:0] rdy_mask = '1;
  logic [KN-1:0] last_acc;

  clos_cm_sync #(.KN(KN), .DW(DW), .BD(BD)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_eof(in_eof), .in_dec(in_dec),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_eof(out_eof), .out_vld(out_vld),
    .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [KN-1:0] d);
    int r = -1;
    for (int k = KN - 1; k >= 0; k--) if (d[k]) r = k;
    return r;
  endfunction

  // Packet-level reference: each input delivers its non-dropped packets in
  // order; a packet goes whole to the lowest requested output. Data carries
  // {input id, per-input sequence} so the monitor can identify the source.
  task automatic add_pkt(input int i, input logic [KN-1:0] dec, input int len);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.data = {3'(i), 5'(seq[i])};
      seq[i]++;
      f.eof  = (k == len - 1);
      f.dec  = (k == 0) ? dec : KN'($urandom);
      f.dst  = lowest(dec);
      send_q[i].push_back(f);
      if (dec != '0) exp_q[i].push_back(f);
    end
  endtask

  // Monitor: every output transfer is popped against the expected queue.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      for (int o = 0; o < KN; o++) begin
        if (out_vld[o] && out_rdy[o]) begin
          logic [DW-1:0] d;
          int            src;
          flit_t         e;
          d   = out_data[o*DW +: DW];
          src = int'(d[DW-1:DW-3]);
          n_xfer++;
          if (cur_in[o] >= 0) chk("no_interleave", src, cur_in[o]);
          else gnt_log[o].push_back(src);
          if (src >= KN || exp_q[src].size() == 0) begin
            chk("unexpected_flit_src", src, -1);
          end else begin
            e = exp_q[src].pop_front();
            chk("flit_dst", o, e.dst);
            chk("flit_data", d, e.data);
            chk("flit_eof", out_eof[o], e.eof);
          end
          cur_in[o] = out_eof[o] ? -1 : src;
        end
      end
    end
  end

  task automatic step();
    for (int i = 0; i < KN; i++) begin
      if (send_q[i].size() > 0 && $urandom_range(99) < vld_pct) begin
        in_vld[i]            = 1'b1;
        in_data[i*DW +: DW]  = send_q[i][0].data;
        in_eof[i]            = send_q[i][0].eof;
        in_dec[i*KN +: KN]   = send_q[i][0].dec;
      end else begin
        in_vld[i] = 1'b0;
      end
    end
    for (int o = 0; o < KN; o++)
      out_rdy[o] = rdy_mask[o] && ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    last_acc = in_vld & in_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < KN; i++) if (last_acc[i]) send_q[i].delete(0);
    in_vld = '0;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < budget) begin
      busy = 1'b0;
      for (int i = 0; i < KN; i++)
        if (send_q[i].size() > 0 || exp_q[i].size() > 0) busy = 1'b1;
      if (busy) begin
        step();
        n++;
      end
    end
    chk(name, busy, 0);
  endtask

  task automatic clear_log();
    for (int o = 0; o < KN; o++) gnt_log[o].delete();
  endtask

  initial begin
    int acc;
    int n0;
    in_data = '0; in_eof = '0; in_dec = '0; in_vld = '0; out_rdy = '1;
    for (int i = 0; i < KN; i++) begin
      cur_in[i] = -1;
      seq[i] = 0;
    end

    // Reset held three cycles with every input requesting.
    rst = 1'b1;
    in_vld = '1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_data", out_data, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_vld = '0;
    @(negedge clk);
    chk("rdy_after_reset", in_rdy, 5'b11111);

    // Single flit input 0 -> output 2.
    @(posedge clk);
    #1;
    in_vld = 5'b00001;
    in_data[DW-1:0] = 8'hA5;
    in_eof = 5'b00001;
    in_dec[KN-1:0] = 5'b00100;
    @(negedge clk);
    chk("single_accept", in_rdy[0], 1);
`ifdef CLOS_CM_BYPASS_EN
    chk("single_bypass_vld", out_vld, 5'b00100);
    chk("single_bypass_data", out_data[2*DW +: DW], 8'hA5);
`else
    chk("single_t0_vld", out_vld, 0);
`endif
    @(posedge clk);
    #1;
    in_vld = '0;
    @(negedge clk);
`ifdef CLOS_CM_BYPASS_EN
    chk("single_t1_vld", out_vld, 0);
`else
    chk("single_t1_vld", out_vld, 5'b00100);
    chk("single_t1_data", out_data[2*DW +: DW], 8'hA5);
    chk("single_t1_eof", out_eof[2], 1);
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single_after_vld", out_vld, 0);
    @(posedge clk);
    #1;

    // Output 2 must still be free for another input.
    mon_en = 1'b1;
    clear_log();
    add_pkt(1, 5'b00100, 1);
    drain(50, "free_drain");
    chk("free_cnt", gnt_log[2].size(), 1);
    if (gnt_log[2].size() == 1) chk("free_src", gnt_log[2][0], 1);

    // Contention on output 4 from inputs 1 and 3.
    clear_log();
    add_pkt(1, 5'b10000, 3);
    add_pkt(3, 5'b10000, 3);
    drain(100, "cont_drain");
    chk("cont_cnt", gnt_log[4].size(), 2);
    if (gnt_log[4].size() == 2) begin
      chk("cont_first", gnt_log[4][0], 1);
      chk("cont_second", gnt_log[4][1], 3);
    end
    // Pointer now at 4: input 4 beats input 3.
    clear_log();
    add_pkt(3, 5'b10000, 1);
    add_pkt(4, 5'b10000, 1);
    drain(50, "rrptr_drain");
    chk("rrptr_cnt", gnt_log[4].size(), 2);
    if (gnt_log[4].size() == 2) begin
      chk("rrptr_first", gnt_log[4][0], 4);
      chk("rrptr_second", gnt_log[4][1], 3);
    end

    // Backpressure: output 0 stalled, input 2 streams 6 flits.
    rdy_mask = 5'b11110;
    add_pkt(2, 5'b00001, 6);
    acc = 0;
    repeat (6) begin
      step();
      acc += int'(last_acc[2]);
    end
    chk("bp_accepts", acc, BD);
    chk("bp_in_rdy", in_rdy[2], 0);
    rdy_mask = '1;
    drain(100, "bp_drain");

    // Fairness: all inputs stream single flits to output 1.
    clear_log();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < KN; i++) add_pkt(i, 5'b00010, 1);
    drain(100, "rr_drain");
    chk("rr_cnt", gnt_log[1].size(), 2 * KN);
    if (gnt_log[1].size() == 2 * KN)
      for (int k = 0; k < 2 * KN; k++) chk("rr_order", gnt_log[1][k], k % KN);

    // Drop: dec=0 two-flit packet is consumed silently.
    clear_log();
    n0 = n_xfer;
    add_pkt(0, 5'b00000, 2);
    add_pkt(0, 5'b01000, 1);
    drain(50, "drop_drain");
    chk("drop_xfers", n_xfer - n0, 1);
    chk("drop_cnt", gnt_log[3].size(), 1);

    // Randomized traffic against the packet-level model.
    vld_pct = 70;
    rdy_pct = 70;
    repeat (150) begin
      int i, r, len;
      logic [KN-1:0] dec;
      i   = $urandom_range(KN - 1);
      r   = $urandom_range(9);
      len = $urandom_range(1, 4);
      if (r == 0) dec = '0;
      else if (r < 3) dec = KN'($urandom);
      else dec = KN'(1 << $urandom_range(KN - 1));
      add_pkt(i, dec, len);
    end
    drain(20000, "rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clos_cm_sync.md
Name: clos_cm_sync

Overview:
- Synchronous, buffered central module (CM) for the SDM-Clos router; next generation of the asynchronous CM stage.
- Switches KN input ports to KN output ports, wormhole style. Each input has a BD-deep flit FIFO.
- Each output has a round-robin arbiter with packet locking. Ports use valid/ready handshakes.
- Sits between the IM and OM stages; one instance per CM (MN instances per router).

Parameters:
- KN, 5: number of input ports and number of output ports.
- DW, 8: flit data width per port.
- BD, 4: input FIFO depth; must be a power of two, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_data  in  KN*DW  input flit data; port i occupies bits [i*DW +: DW]
- in_eof  in  KN  tail flag per input flit
- in_dec  in  KN*KN  one-hot requested output per input; port i occupies [i*KN +: KN]; sampled with every flit, used only on head flits
- in_vld  in  KN  input flit valid
- in_rdy  out  KN  input can accept a flit
- out_data  out  KN*DW  output flit data
- out_eof  out  KN  output tail flag
- out_vld  out  KN  output flit valid
- out_rdy  in  KN  downstream (OM) accepts the flit

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- Reset state:
  - All FIFOs empty; all output locks clear; all round-robin pointers 0.
  - While rst=1: in_rdy=0 and out_vld=0; out_data and out_eof are 0.
  - On the first cycle after reset deasserts: in_rdy=all ones.
- Reset mid-operation discards buffered flits and locks. Packets truncated downstream are the system's responsibility.
- Input FIFO:
  - Push when in_vld[i]&&in_rdy[i]. Each entry is {eof, dec, data}.
  - in_rdy[i] = !full[i], registered from occupancy. A full FIFO refuses a push even in a cycle where it pops.
  - Write latency 1: a flit accepted in cycle t is at the FIFO head in cycle t+1.
  - Pointers are log2(BD)+1 bits, wrapping modulo 2*BD. Occupancy counter ranges 0..BD.
- Per-input state:
  - IDLE: head flit is a packet head.
  - BOUND(o): input owns output o.
- Per-output state:
  - FREE, or LOCKED(owner).
- Arbitration (combinational, per cycle):
  - Each FREE output o grants one requester among IDLE inputs with a non-empty FIFO whose head dec selects o.
  - Priority is round-robin, starting at rr_ptr[o].
  - Multi-hot dec: lowest set bit is the request.
  - dec=0: the head flit is popped and dropped in that cycle with no output activity; a multi-flit packet drains until eof.
- Datapath (combinational from FIFO head through crossbar):
  - out_vld[o]=1 when o is granted or LOCKED and the owner's FIFO is non-empty.
  - Transfer = out_vld[o]&&out_rdy[o]; it pops the owner's FIFO.
- Lock rules, applied at the clock edge after a transfer:
  - Head transfer without eof: output becomes LOCKED(i), input becomes BOUND(o), rr_ptr[o]=(i+1) mod KN.
  - Head transfer with eof (single-flit packet): output stays FREE; rr_ptr still updates.
  - Tail transfer (eof) on a LOCKED output: output returns to FREE and input to IDLE; re-arbitration happens the next cycle.
  - A grant without a transfer (out_rdy=0) does not lock and does not update rr_ptr. Arbitration re-runs the next cycle, so the winner may change.
- Minimum latency: input accept to out_vld is 1 cycle. Throughput is 1 flit/cycle/output.
- Simultaneous events: different outputs are independent. A single input is bound to at most one output. A push and pop on the same FIFO in the same cycle keeps occupancy unchanged.

Optional Feature:
- Macro: CLOS_CM_BYPASS_EN
- Defined:
  - An empty FIFO whose input is IDLE or BOUND passes in_data/in_eof/in_dec straight to the arbiter/crossbar in the same cycle (0-cycle latency).
  - The FIFO is written only if the flit does not transfer.
  - in_rdy is unchanged.
- Undefined: minimum latency is 1 cycle, as specified above.

Decomposition:
- Package clos_cm_pkg holds:
  - function clog2;
  - function onehot_lowest (KN-bit vector to index);
  - typedef enum {IDLE, BOUND} in_st_t;
  - localparam PW=clog2(BD)+1.
- Sub-module clos_rr_arb: KN-request round-robin arbiter with pointer input, one-hot grant output and grant-valid. It is instantiated once per output.
- FIFOs and lock registers stay inline.

Test Plan:
- Reset: hold rst 3 cycles with in_vld=all ones -> in_rdy=0 and out_vld=0 throughout; in_rdy=5'b11111 on the first cycle after release.
- Single flit: input 0, data 8'hA5, eof=1, dec=5'b00100 at t -> out_vld[2]=1, out_data[2]=8'hA5 at t+1; output 2 remains FREE afterwards.
- Contention: inputs 1 and 3 each send a 3-flit packet to output 4, rr_ptr=0 -> input 1 is delivered fully, then input 3, with no interleaving; rr_ptr[4] ends at 4.
- Backpressure: out_rdy[0]=0 for 6 cycles while input 2 sends 6 flits to output 0 -> in_rdy[2]=0 after 4 accepts; all 6 flits arrive in order once out_rdy=1.
- Round-robin fairness: inputs 0–4 all stream single-flit packets to output 1 -> grants cycle 0,1,2,3,4,0 exactly.
- Drop and bypass: dec=0 on a 2-flit packet -> both flits consumed, nothing emitted. With CLOS_CM_BYPASS_EN, a flit to an idle output appears on out_vld in the same cycle as in_vld.
